// File: rtl/sqrt_arbiter.sv
// Round-robin front end that shares one pipelined square-root unit among N_REQ clients.
// Tracks the owner of every in-flight radicand and steers each root back with a one-hot strobe.
module sqrt_arbiter #(
  parameter int N_REQ           = 4,
  parameter int WIDTH_INPUT     = 16,
  parameter int WIDTH_OUTPUT    = WIDTH_INPUT/2 + WIDTH_INPUT%2,
  parameter int LATENCY         = WIDTH_OUTPUT,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*WIDTH_INPUT-1:0] req_radicand,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         sq_valid_in,
  output logic [WIDTH_INPUT-1:0]       sq_radicand,
  input  logic                         sq_valid_out,
  input  logic [WIDTH_OUTPUT-1:0]      sq_root,
  output logic [N_REQ-1:0]             resp_valid,
  output logic [WIDTH_OUTPUT-1:0]      resp_root,
  output logic                         busy,
  output logic                         protocol_error
);

  localparam int              IDX_W    = $clog2(N_REQ);
  localparam logic [IDX_W:0]  N_REQ_X  = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ-1);
  localparam logic [3:0]      MAX_CNT  = 4'(MAX_OUTSTANDING);

  logic [IDX_W-1:0]       rr_ptr;
  logic [N_REQ-1:0]       eligible;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_found;
  logic [IDX_W:0]         scan_idx;
  logic                   accept;
  logic [N_REQ-1:0]       accept_vec;
  logic [WIDTH_INPUT-1:0] sel_radicand;
  logic [3:0]             outstanding [N_REQ];
  logic [IDX_W-1:0]       issue_owner;
  logic [LATENCY-1:0]     tag_valid;
  logic [IDX_W-1:0]       tag_owner [LATENCY];
  logic                   tag_end_valid;
  logic [IDX_W-1:0]       tag_end_owner;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (outstanding[i] < MAX_CNT);
    end
  end

  // Scan N_REQ positions starting at rr_ptr; first eligible index wins.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_idx >= N_REQ_X) scan_idx = scan_idx - N_REQ_X;
      if (!grant_found && eligible[scan_idx[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  // Grants are masked while reset is asserted so nothing is offered to clients.
  always_comb begin
    req_ready = '0;
    if (grant_found && rst_n) req_ready[grant_idx] = 1'b1;
  end

  assign accept_vec   = req_valid & req_ready;
  assign accept       = |accept_vec;
  assign sel_radicand = req_radicand[grant_idx*WIDTH_INPUT +: WIDTH_INPUT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      sq_valid_in <= 1'b0;
      sq_radicand <= '0;
      issue_owner <= '0;
    end else begin
      sq_valid_in <= accept;
      if (accept) begin
        sq_radicand <= sel_radicand;
        issue_owner <= grant_idx;
        rr_ptr      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  // Tag stage 0 follows the registered issue, so the last stage lines up with sq_valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int s = 0; s < LATENCY; s++) tag_owner[s] <= '0;
    end else begin
      tag_valid[0] <= sq_valid_in;
      tag_owner[0] <= issue_owner;
      for (int s = 1; s < LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_owner[s] <= tag_owner[s-1];
      end
    end
  end

  assign tag_end_valid = tag_valid[LATENCY-1];
  assign tag_end_owner = tag_owner[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid     <= '0;
      resp_root      <= '0;
      protocol_error <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (sq_valid_out && tag_end_valid) begin
        resp_valid <= N_REQ'(1) << tag_end_owner;
        resp_root  <= sq_root;
      end
      if (sq_valid_out != tag_end_valid) protocol_error <= 1'b1;
    end
  end

  // Credits are returned on the response pulse, so a stalled client resumes one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept_vec[i] && !resp_valid[i])
          outstanding[i] <= outstanding[i] + 4'd1;
        else if (!accept_vec[i] && resp_valid[i])
          outstanding[i] <= outstanding[i] - 4'd1;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (outstanding[i] != 4'd0) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural 8-stage root unit attached.
module tb_sqrt_arbiter;

  localparam int LAT = 8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_radicand;
  logic [3:0]  req_ready;
  logic        sq_valid_in;
  logic [15:0] sq_radicand;
  logic        sq_valid_out;
  logic [7:0]  sq_root;
  logic [3:0]  resp_valid;
  logic [7:0]  resp_root;
  logic        busy;
  logic        protocol_error;
  logic        spur;

  logic [LAT-1:0] m_valid;
  logic [7:0]     m_root [LAT];

  int n_checks = 0;
  int n_errors = 0;

  sqrt_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_radicand   (req_radicand),
    .req_ready      (req_ready),
    .sq_valid_in    (sq_valid_in),
    .sq_radicand    (sq_radicand),
    .sq_valid_out   (sq_valid_out),
    .sq_root        (sq_root),
    .resp_valid     (resp_valid),
    .resp_root      (resp_root),
    .busy           (busy),
    .protocol_error (protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] isqrt(input logic [15:0] x);
    logic [7:0] r;
    r = 8'd0;
    for (int c = 0; c < 256; c++) if (c * c <= int'(x)) r = 8'(c);
    return r;
  endfunction

  // Stand-in for the shared root unit: fixed latency, same reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= '0;
      for (int s = 0; s < LAT; s++) m_root[s] <= '0;
    end else begin
      m_valid   <= {m_valid[LAT-2:0], sq_valid_in};
      m_root[0] <= isqrt(sq_radicand);
      for (int s = 1; s < LAT; s++) m_root[s] <= m_root[s-1];
    end
  end

  assign sq_valid_out = m_valid[LAT-1] | spur;
  assign sq_root      = m_root[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  logic [7:0] fair_root [4] = '{8'd0, 8'd1, 8'd255, 8'd2};

  initial begin
    rst_n        = 1'b0;
    req_valid    = 4'h0;
    req_radicand = '0;
    spur         = 1'b0;
    #3;
    req_valid = 4'hf;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_sq_valid_in", 32'(sq_valid_in), 32'd0);
    chk("rst_sq_radicand", 32'(sq_radicand), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_root", 32'(resp_root), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(protocol_error), 32'd0);
    repeat (2) tick();
    rst_n     = 1'b1;
    req_valid = 4'h0;
    tick();

    // single request, radicand 144
    req_radicand = {48'd0, 16'd144};
    for (int c = 0; c < 12; c++) begin
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 0) chk("single_grant", 32'(req_ready), 32'h1);
      if (c == 1) begin
        chk("single_issue", 32'(sq_valid_in), 32'd1);
        chk("single_radicand", 32'(sq_radicand), 32'd144);
      end
      chk("single_busy", 32'(busy), (c >= 1 && c <= 10) ? 32'd1 : 32'd0);
      chk("single_resp", 32'(resp_valid), (c == 10) ? 32'h1 : 32'h0);
      if (c == 10) chk("single_root", 32'(resp_root), 32'd12);
      tick();
    end

    // fairness: all four requesters valid
    do_reset();
    req_radicand = {16'd4, 16'd65535, 16'd1, 16'd0};
    for (int c = 0; c < 20; c++) begin
      req_valid = (c < 8) ? 4'hf : 4'h0;
      #1;
      chk("fair_grant", 32'(req_ready), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      chk("fair_resp", 32'(resp_valid), (c >= 10 && c < 18) ? (32'd1 << ((c - 10) % 4)) : 32'd0);
      if (c >= 10 && c < 18) chk("fair_root", 32'(resp_root), 32'(fair_root[(c - 10) % 4]));
      tick();
    end

    // credit limit on requester 2
    req_radicand = {16'd0, 16'd100, 16'd0, 16'd0};
    for (int c = 0; c < 12; c++) begin
      req_valid = 4'b0100;
      #1;
      chk("credit_grant", 32'(req_ready), (c <= 3 || c == 11) ? 32'h4 : 32'h0);
      if (c == 10) begin
        chk("credit_resp", 32'(resp_valid), 32'h4);
        chk("credit_root", 32'(resp_root), 32'd10);
      end
      tick();
    end
    req_valid = 4'h0;
    drain("credit_drain");

    // pointer wrap: last grant was requester 2, so 3 then 0
    req_radicand = {16'd49, 16'd0, 16'd0, 16'd81};
    req_valid = 4'b1000;
    #1;
    chk("wrap_first", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("wrap_second", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'h0;
    drain("wrap_drain");
    chk("wrap_last_root", 32'(resp_root), 32'd9);

    // spurious completion
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    #1;
    chk("spur_err", 32'(protocol_error), 32'd1);
    chk("spur_resp", 32'(resp_valid), 32'd0);
    repeat (3) tick();
    chk("spur_sticky", 32'(protocol_error), 32'd1);
    chk("spur_busy", 32'(busy), 32'd0);

    // reset with three operations in flight
    req_radicand = {16'd0, 16'd9, 16'd4, 16'd1};
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = 4'h0;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    req_valid = 4'b0111;
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(req_ready), 32'd0);
    chk("mid_sq_valid_in", 32'(sq_valid_in), 32'd0);
    chk("mid_sq_radicand", 32'(sq_radicand), 32'd0);
    chk("mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_resp_root", 32'(resp_root), 32'd0);
    chk("mid_busy_clr", 32'(busy), 32'd0);
    chk("mid_perr_clr", 32'(protocol_error), 32'd0);
    req_valid = 4'h0;
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 14; c++) begin
      #1;
      chk("post_rst_resp", 32'(resp_valid), 32'd0);
      tick();
    end
    chk("post_rst_perr", 32'(protocol_error), 32'd0);

    // fresh request after reset, radicand 225 on requester 1
    req_radicand = {16'd0, 16'd0, 16'd225, 16'd0};
    for (int c = 0; c < 11; c++) begin
      req_valid = (c == 0) ? 4'b0010 : 4'b0000;
      #1;
      if (c == 0) chk("fresh_grant", 32'(req_ready), 32'h2);
      chk("fresh_resp", 32'(resp_valid), (c == 10) ? 32'h2 : 32'h0);
      if (c == 10) chk("fresh_root", 32'(resp_root), 32'd15);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
